// File: rtl/risc_controller.sv
// Multi-cycle Moore sequencer for the RISC datapath: decodes opcode/op once per
// start pulse and steps register file, A/B/C registers, status and ALU controls.
module risc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [1:0] ALUop
);

    typedef enum logic [2:0] {
        WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] opcode_reg;
    logic [1:0] op_reg;

    logic is_alu_class, is_mov_imm, is_mov_reg, is_mvn, is_cmp;

    assign is_alu_class = (opcode_reg == 3'b101);
    assign is_mov_imm   = (opcode_reg == 3'b110) && (op_reg == 2'b10);
    assign is_mov_reg   = (opcode_reg == 3'b110) && (op_reg == 2'b00);
    assign is_mvn       = is_alu_class && (op_reg == 2'b11);
    assign is_cmp       = is_alu_class && (op_reg == 2'b01);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT:      if (s) state_next = DECODE;
            DECODE: begin
                if (is_mov_imm)                 state_next = WRITE_IMM;
                else if (is_mov_reg || is_mvn)  state_next = GET_B;
                else if (is_alu_class)          state_next = GET_A;
                else                            state_next = WAIT;
            end
            GET_A:     state_next = GET_B;
            GET_B:     state_next = ALU;
            ALU:       state_next = is_cmp ? WAIT : WRITE_REG;
            WRITE_REG: state_next = WAIT;
            WRITE_IMM: state_next = WAIT;
            default:   state_next = WAIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= WAIT;
            opcode_reg <= 3'b000;
            op_reg     <= 2'b00;
            w          <= 1'b1;
            nsel       <= 3'b000;
            vsel       <= 2'b00;
            write      <= 1'b0;
            loada      <= 1'b0;
            loadb      <= 1'b0;
            asel       <= 1'b0;
            bsel       <= 1'b0;
            loadc      <= 1'b0;
            loads      <= 1'b0;
            ALUop      <= 2'b00;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT && s) begin
                opcode_reg <= opcode;
                op_reg     <= op;
            end
            w     <= 1'b0;
            nsel  <= 3'b000;
            vsel  <= 2'b00;
            write <= 1'b0;
            loada <= 1'b0;
            loadb <= 1'b0;
            asel  <= 1'b0;
            bsel  <= 1'b0;
            loadc <= 1'b0;
            loads <= 1'b0;
            ALUop <= 2'b00;
            case (state_next)
                WAIT:  w <= 1'b1;
                GET_A: begin
                    nsel  <= 3'b100;
                    loada <= 1'b1;
                end
                GET_B: begin
                    nsel  <= 3'b001;
                    loadb <= 1'b1;
                end
                ALU: begin
                    loadc <= 1'b1;
                    loads <= is_cmp;
                    // MOV reg passes B through as 0 + B; MVN ignores A anyway.
                    asel  <= is_mov_reg || is_mvn;
                    ALUop <= is_alu_class ? op_reg : 2'b00;
                end
                WRITE_REG: begin
                    nsel  <= 3'b010;
                    write <= 1'b1;
                end
                WRITE_IMM: begin
                    nsel  <= 3'b100;
                    vsel  <= 2'b01;
                    write <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/risc_controller.md
# risc_controller

Multi-cycle Moore sequencer for the RISC machine datapath. It decodes the instruction class on `opcode`/`op` and steps the register file, A/B/C pipeline registers, status register and ALU through the cycles each instruction needs. It sits between the instruction register and the datapath. It issues one instruction per `s` pulse and signals completion on `w`.

## Interface
Parameters: none. Field encodings are fixed by the ISA.

- `clk` in 1 — single clock; all state changes on rising edge.
- `reset` in 1 — synchronous, active-high; forces state WAIT.
- `s` in 1 — start; sampled only in WAIT.
- `opcode` in 3 — instruction bits [15:13].
- `op` in 2 — instruction bits [12:11].
- `w` out 1 — 1 only in WAIT (idle/ready).
- `nsel` out 3 — one-hot register-file select: 100 = Rn, 010 = Rd, 001 = Rm, 000 = none.
- `vsel` out 2 — write-back source: 00 = datapath C, 01 = sign-extended imm8; 10/11 never driven.
- `write` out 1 — register-file write enable.
- `loada` out 1 — load A register.
- `loadb` out 1 — load B register.
- `asel` out 1 — 1 forces ALU A input to 0.
- `bsel` out 1 — 1 selects imm5 for B. Always 0 in this ISA subset.
- `loadc` out 1 — load C register.
- `loads` out 1 — load status register (NVZ).
- `ALUop` out 2 — ALU operation: 00 add, 01 sub, 10 and, 11 not-B.

## Operation
- `opcode`/`op` are latched into an internal decode register on the WAIT→DECODE transition. Input changes during execution are ignored.
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
- Every other encoding is a NOP: DECODE→WAIT with no write, load or status update.
- States and transitions:
  - WAIT: `s`=1 → DECODE; otherwise stay.
  - DECODE: MOV imm → WRITE_IMM; MOV reg / MVN → GET_B; ADD / CMP / AND → GET_A; unsupported → WAIT.
  - GET_A → GET_B.
  - GET_B → ALU.
  - ALU: CMP → WAIT; otherwise → WRITE_REG.
  - WRITE_REG → WAIT.
  - WRITE_IMM → WAIT.
- Outputs are Moore, decoded from state and latched fields. Any output not listed for a state is 0:
  - WAIT: `w`=1.
  - GET_A: `nsel`=100, `loada`=1.
  - GET_B: `nsel`=001, `loadb`=1.
  - ALU: `loadc`=1, `ALUop` as below, `asel` as below, `loads`=1 for CMP only.
  - WRITE_REG: `nsel`=010, `vsel`=00, `write`=1.
  - WRITE_IMM: `nsel`=100, `vsel`=01, `write`=1.
- `ALUop` in ALU state:
  - ALU class (opcode 101): latched `op`.
  - MOV reg: 00, with `asel`=1 (A forced to 0, so result = B).
  - MVN: `asel` is 1; the ALU ignores A for not-B.
  - Outside the ALU state: 00.
- ADD / CMP / AND: `asel`=0.
- `bsel` is 0 in every state.

## Timing
- Reset: on any edge with `reset`=1 the FSM goes to WAIT, regardless of state or `s`. `reset` takes priority over `s`.
- Reset values of outputs: `w`=1; all others 0 (`nsel`=000, `vsel`=00, `ALUop`=00). The decode register clears to 000/00.
- Reset mid-instruction abandons the instruction. There is no further `write`/`loads` pulse after the reset edge.
- Cycle 0 is the WAIT cycle where `s`=1 is sampled. `w` returns to 1 at:
  - MOV imm: cycle 3 (`write` in cycle 2).
  - MOV reg / MVN: cycle 5 (`loadb` in 2, `loadc` in 3, `write` in 4).
  - ADD / AND: cycle 6 (`loada` in 2, `loadb` in 3, `loadc` in 4, `write` in 5).
  - CMP: cycle 5 (`loadc`+`loads` in 4, no `write`).
  - Unsupported: cycle 2.
- `s` held high through completion starts the next instruction on the first WAIT cycle. There are no idle cycles between back-to-back instructions.
- `s` asserted outside WAIT has no effect.
- Each load or `write` strobe is exactly one cycle wide.

## Test plan
- Reset, then hold `reset`=1 and `s`=1 for 3 cycles → `w`=1 and all other outputs 0 throughout. Release reset → WAIT→DECODE.
- `opcode`=110, `op`=10, pulse `s` → cycle 2: `nsel`=100, `vsel`=01, `write`=1; cycle 3: `w`=1. Change `opcode` to 101 in cycle 1 → path unchanged.
- ADD (101/00) → cycles 2–5: `loada`, `loadb`, `loadc` with `ALUop`=00 and `asel`=0, then `write` with `nsel`=010, `vsel`=00. `loads`=0 throughout. `w`=1 at cycle 6.
- CMP (101/01) → cycle 4: `loadc`=1, `loads`=1, `ALUop`=01. No `write` pulse at any cycle. `w`=1 at cycle 5.
- MOV reg (110/00) and MVN (101/11) → GET_A skipped. Cycle 3: `asel`=1 with `ALUop`=00 (MOV) or 11 (MVN). `write` in cycle 4.
- Unsupported `opcode`=000 → `w`=1 at cycle 2 with no strobes. `reset` asserted during an ADD's GET_B → next cycle WAIT and no `write`.
